// File: rtl/mux_pipe_n.sv
// Registered N-way mux with valid/ready on every channel and a one-deep output register.
// Define MUX_PIPE_RR_EN for round-robin arbitration instead of the explicit sel input.
module mux_pipe_n #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Handshake: a word moves on a rising edge when valid && ready are both high;
    // ready never depends on the same channel's valid in fixed mode, and valid
    // never waits for ready on the output side.
    logic [WIDTH-1:0] words [NUM_IN];
    logic [SEL_W-1:0] chosen;
    logic             have_sel;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] word;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign words[g] = in_data[g*WIDTH +: WIDTH];
    end

`ifdef MUX_PIPE_RR_EN
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    wire              unused_sel = ^sel;

    // Scan offsets from high to low so the nearest valid channel after ptr wins.
    always_comb begin
        chosen   = '0;
        have_sel = 1'b0;
        rr_idx   = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            rr_idx = SEL_W'((int'(ptr) + k) % NUM_IN);
            if (in_valid[rr_idx]) begin
                chosen   = rr_idx;
                have_sel = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (int'(chosen) == NUM_IN - 1) ? '0 : chosen + 1'b1;
        end
    end
`else
    assign chosen   = sel;
    assign have_sel = int'(sel) < NUM_IN;
`endif

    assign can_load = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        word     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (SEL_W'(i) == chosen) begin
                word        = words[i];
                in_ready[i] = rst_n && can_load && have_sel;
            end
        end
    end

    assign load = |(in_ready & in_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_sel   <= chosen;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Directed bench for mux_pipe_n: vector table for fixed-select mode plus hand-written
// sequences for reset-under-stall, illegal select (3-input instance) and round-robin.
module tb_mux_pipe_n;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] in3_data;
    logic [2:0]  in3_valid;
    logic [2:0]  in3_ready;
    logic [1:0]  sel3;
    logic [15:0] out3_data;
    logic [1:0]  out3_sel;
    logic        out3_valid;
    logic        out3_ready;

    int n_total;
    int n_pass;

    mux_pipe_n #(.WIDTH(16), .NUM_IN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_sel(out_sel),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_pipe_n #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in3_data), .in_valid(in3_valid),
        .in_ready(in3_ready), .sel(sel3), .out_data(out3_data), .out_sel(out3_sel),
        .out_valid(out3_valid), .out_ready(out3_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [63:0] data;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_ir;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] pack4(input int d0, input int d1, input int d2, input int d3);
        return {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Drive at the falling edge, check ready combinationally, then outputs after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        sel       = v.sel;
        in_data   = v.data;
        in_valid  = v.valid;
        out_ready = v.ordy;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(v.exp_ir));
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(v.exp_ov));
        check({tag, ".out_data"}, 32'(out_data), 32'(v.exp_od));
        check({tag, ".out_sel"}, 32'(out_sel), 32'(v.exp_os));
    endtask

    task automatic add(input logic [1:0] s, input logic [63:0] d, input logic [3:0] v,
                       input logic r, input logic [3:0] ir, input logic ov,
                       input int od, input logic [1:0] os);
        vec_t x;
        x.sel = s; x.data = d; x.valid = v; x.ordy = r;
        x.exp_ir = ir; x.exp_ov = ov; x.exp_od = 16'(od); x.exp_os = os;
        vecs.push_back(x);
    endtask

    task automatic rr_step(input logic [3:0] v, input logic [1:0] exp_os, input string tag);
        @(negedge clk);
        in_data   = pack4(100, 101, 102, 103);
        in_valid  = v;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_sel"}, 32'(out_sel), 32'(exp_os));
        check({tag, ".out_data"}, 32'(out_data), 32'(100 + int'(exp_os)));
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        sel        = '0;
        in_data    = '0;
        in_valid   = '0;
        out_ready  = 1'b0;
        in3_data   = '0;
        in3_valid  = '0;
        sel3       = '0;
        out3_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef MUX_PIPE_RR_EN
        add(2'd0, pack4(20, 60, 95, 70), 4'hF, 1, 4'b0001, 1, 20, 0);
        add(2'd1, pack4(20, 70, 95, 70), 4'hF, 1, 4'b0010, 1, 70, 1);
        add(2'd2, pack4(20, 70, 1, 70),  4'hF, 1, 4'b0100, 1, 1, 2);
        add(2'd3, pack4(20, 70, 1, 13),  4'hF, 1, 4'b1000, 1, 13, 3);
        add(2'd0, pack4(50, 70, 1, 13),  4'hF, 1, 4'b0001, 1, 50, 0);
        add(2'd0, pack4(40, 70, 1, 13),  4'hF, 0, 4'b0000, 1, 50, 0);
        add(2'd0, pack4(40, 70, 1, 13),  4'hF, 0, 4'b0000, 1, 50, 0);
        add(2'd0, pack4(40, 70, 1, 13),  4'hF, 0, 4'b0000, 1, 50, 0);
        add(2'd0, pack4(40, 70, 1, 13),  4'hF, 1, 4'b0001, 1, 40, 0);
        add(2'd2, pack4(40, 70, 51, 13), 4'hF, 1, 4'b0100, 1, 51, 2);
        add(2'd2, pack4(40, 70, 51, 13), 4'h0, 1, 4'b0100, 0, 51, 2);
        add(2'd1, pack4(40, 70, 51, 13), 4'h0, 0, 4'b0010, 0, 51, 2);
        add(2'd1, pack4(40, 7, 51, 13),  4'b0010, 0, 4'b0010, 1, 7, 1);
        add(2'd3, pack4(40, 7, 51, 13),  4'b0001, 1, 4'b1000, 0, 7, 1);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Three-input instance: sel=3 names no channel.
        @(negedge clk);
        sel3 = 2'd1; in3_data = {16'd5, 16'd33, 16'd4}; in3_valid = 3'b111; out3_ready = 1'b1;
        #1;
        check("ill.load.in_ready", 32'(in3_ready), 32'b010);
        @(posedge clk); #1;
        check("ill.load.out_data", 32'(out3_data), 32'd33);
        check("ill.load.out_valid", 32'(out3_valid), 32'd1);
        @(negedge clk);
        sel3 = 2'd3;
        #1;
        check("ill.sel3.in_ready", 32'(in3_ready), 32'b000);
        @(posedge clk); #1;
        check("ill.drain.out_valid", 32'(out3_valid), 32'd0);
        @(posedge clk); #1;
        check("ill.idle.out_valid", 32'(out3_valid), 32'd0);
        check("ill.idle.out_data", 32'(out3_data), 32'd33);
`endif

        // Reset while a word is held under back-pressure.
        @(negedge clk);
        sel = 2'd0; in_data = pack4(99, 0, 0, 0); in_valid = 4'b0001; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst.load.out_data", 32'(out_data), 32'd99);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst.stall.out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n = 1'b0; out_ready = 1'b1;
        #1;
        check("rst.low.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.out_sel", 32'(out_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst.after.out_valid", 32'(out_valid), 32'd0);

`ifdef MUX_PIPE_RR_EN
        rr_step(4'hF, 2'd0, "rr.all0");
        rr_step(4'hF, 2'd1, "rr.all1");
        rr_step(4'hF, 2'd2, "rr.all2");
        rr_step(4'hF, 2'd3, "rr.all3");
        rr_step(4'hF, 2'd0, "rr.all4");
        rr_step(4'b1010, 2'd1, "rr.odd0");
        rr_step(4'b1010, 2'd3, "rr.odd1");
        rr_step(4'b1010, 2'd1, "rr.odd2");
        rr_step(4'b1010, 2'd3, "rr.odd3");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
